pattern_scan_ctrl: RTL
======================

// Module: pattern_scan_ctrl
// PURPOSE
//  Shares one external serial "0101" Moore detector (overlapping matches; z high in the
//  state reached after the final '1') among NREQ requesters.
//  Picks a requester by round-robin arbitration and captures its WIDTH-bit word.
//  Clears the detector, shifts the word in MSB first, counts z pulses, and returns the
//  match count with the requester id. It sits between client blocks and the detector.
// PARAMETERS
//  NREQ   4  number of requesters (>=2)
//  WIDTH  8  bits per word (>=4)
//  CNT_W  4  width of rsp_count; the count saturates at all-ones
// PORTS
//  clk        in   1            clock, rising edge
//  rst        in   1            asynchronous, active-high reset
//  req_valid  in   NREQ         requester i has a word pending
//  req_data   in   NREQ*WIDTH   word of requester i in bits [i*WIDTH +: WIDTH]
//  req_ready  out  NREQ         one-hot grant; transfer when valid&ready at a clk edge
//  det_x      out  1            serial bit to the detector x input
//  det_rst    out  1            detector reset (registered, glitch-free)
//  det_z      in   1            detector Moore output
//  rsp_valid  out  1            result available
//  rsp_id     out  clog2(NREQ)  index of the requester served
//  rsp_count  out  CNT_W        number of matches in the word
//  rsp_ready  in   1            consumer accepts the result
// BEHAVIOUR
//  Reset (async): state=IDLE, rr pointer=0, shift reg=0, bit cnt=0, count=0.
//   All outputs are 0, including det_rst.
//  States: IDLE -> CLEAR -> SHIFT -> FLUSH -> DONE -> IDLE.
//  IDLE: if any req_valid, grant the first valid requester at or after the rr pointer,
//   searching upward with wrap-around.
//   req_ready of that requester is high this cycle (combinational).
//   At the edge, capture the word and id, set rr pointer = id+1 (mod NREQ), go to CLEAR.
//   With no valid request, req_ready=0 and the block stays in IDLE.
//  CLEAR (1 cycle): det_rst=1, det_x=0, count=0.
//  SHIFT (WIDTH cycles): det_x = word bit WIDTH-1-k in the k-th cycle (MSB first).
//   count += det_z every SHIFT cycle; det_z is 0 in the first cycle (detector in A).
//  FLUSH (1 cycle): det_x=0, count += det_z (result of the last bit).
//  DONE: rsp_valid=1; rsp_id and rsp_count held stable until rsp_valid&rsp_ready.
//   Then go to IDLE. No new grant is given while in DONE.
//  Latency: rsp_valid rises WIDTH+2 cycles after the request handshake edge.
//   Minimum period per word is WIDTH+4 cycles.
//  det_x is 0 outside SHIFT. det_rst is high only in CLEAR.
//  Every word is scanned independently; no match spans two words.
//  Count saturates at 2^CNT_W-1 (unreachable for the defaults, max is 3).
//  req_valid dropping before grant: not granted, no side effect.
//   req_data only needs to be stable during the handshake cycle.
//  Reset mid-operation: the word in flight and its result are discarded.
//   Outputs return to reset values immediately.
//   The rr pointer restarts at 0, and the next word gets a fresh CLEAR.
// TESTING
//  T1 req 0 only, data 8'b0101_0101 -> det_x 0,1,0,1,0,1,0,1; rsp_id=0, rsp_count=3,
//     rsp_valid 10 cycles after the handshake edge.
//  T2 data 8'b0000_0101 -> count 1; 8'b1111_0000 -> 0; 8'b0101_1010 -> 1
//     (the 0101 at bits 7:4 matches; 1010 adds none).
//  T3 all 4 req_valid held from reset -> grants in order 0,1,2,3,0.
//     Each req_ready lasts exactly 1 cycle, and the rsp_id sequence matches the grants.
//  T4 rsp_ready low for 5 cycles in DONE -> rsp_valid, rsp_id, rsp_count stable;
//     req_ready=0 throughout; accepted on the first cycle rsp_ready=1.
//  T5 word A 8'b0000_0010 then word B 8'b1000_0000 from the same requester
//     -> det_rst high for 1 cycle before each; both counts 0, no cross-word match.
//  T6 rst pulsed during the 4th SHIFT cycle -> all outputs 0 immediately, no rsp_valid
//     for that word; after release req 2 alone -> served with a correct count.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// Round-robin front end that time-shares one external serial "0101" Moore detector.
// Each granted word is shifted MSB first after a detector clear, and its z pulses are counted.
module pattern_scan_ctrl #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic                    det_x,
   output logic                    det_rst,
   input  logic                    det_z,
   output logic                    rsp_valid,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [CNT_W-1:0]        rsp_count,
   input  logic                    rsp_ready
);

   localparam int ID_W  = $clog2(NREQ);
   localparam int BIT_W = $clog2(WIDTH);
   localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NREQ - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SHIFT,
      FLUSH,
      DONE
   } state_t;

   state_t            state_reg, state_next;
   logic [ID_W-1:0]   rr_reg, rr_next;
   logic [ID_W-1:0]   id_reg, id_next;
   logic [WIDTH-1:0]  shift_reg, shift_next;
   logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic              det_rst_reg, det_rst_next;

   logic [WIDTH-1:0]  words [NREQ];
   logic              grant_found;
   logic [ID_W-1:0]   grant_id;
   logic [CNT_W-1:0]  count_inc;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_words
         assign words[gi] = req_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Walk offsets from the highest down so the closest valid requester at or
   // after the round-robin pointer is the one left standing.
   always_comb begin
      int cand;
      grant_found = 1'b0;
      grant_id    = '0;
      cand        = 0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         cand = int'(rr_reg) + i;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (req_valid[cand[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_id    = cand[ID_W-1:0];
         end
      end
   end

   assign count_inc = (det_z && (count_reg != {CNT_W{1'b1}})) ? count_reg + CNT_W'(1) : count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         rr_reg      <= '0;
         id_reg      <= '0;
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
         count_reg   <= '0;
         det_rst_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         rr_reg      <= rr_next;
         id_reg      <= id_next;
         shift_reg   <= shift_next;
         bit_cnt_reg <= bit_cnt_next;
         count_reg   <= count_next;
         det_rst_reg <= det_rst_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      rr_next      = rr_reg;
      id_next      = id_reg;
      shift_next   = shift_reg;
      bit_cnt_next = bit_cnt_reg;
      count_next   = count_reg;
      det_rst_next = 1'b0;
      req_ready    = '0;
      det_x        = 1'b0;
      rsp_valid    = 1'b0;

      case (state_reg)
         IDLE: begin
            // The grant is masked while reset is held so every output reads 0.
            if (grant_found && !rst) begin
               req_ready    = NREQ'(1) << grant_id;
               shift_next   = words[grant_id];
               id_next      = grant_id;
               rr_next      = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
               det_rst_next = 1'b1;
               state_next   = CLEAR;
            end
         end
         CLEAR: begin
            count_next   = '0;
            bit_cnt_next = '0;
            state_next   = SHIFT;
         end
         SHIFT: begin
            det_x        = shift_reg[WIDTH-1];
            shift_next   = {shift_reg[WIDTH-2:0], 1'b0};
            count_next   = count_inc;
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
            if (bit_cnt_reg == LAST_BIT) begin
               state_next = FLUSH;
            end
         end
         FLUSH: begin
            // The detector's response to the last bit only appears here.
            count_next = count_inc;
            state_next = DONE;
         end
         DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign det_rst   = det_rst_reg;
   assign rsp_id    = id_reg;
   assign rsp_count = count_reg;

endmodule
